// File: rtl/ifns_encoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ifns_encoder_pipe
// Purpose  : Pipelined Fibonacci-numeral-system crosstalk-avoidance encoder.
//            Maps a DATA_W-bit binary word onto a CODE_W-bit codeword whose
//            bit i-1 carries digit d_i of weight F(i), with F(1)=F(2)=1.
//            Digits are resolved top-down, STG_PER_REG digit stages per
//            pipeline register, behind a valid/ready stream on both sides.
// Ports    : clk        - clock, rising edge
//            rst_n      - synchronous active-low reset
//            in_valid   - input word valid
//            in_ready   - encoder accepts a word this cycle
//            in_data    - binary value v (DATA_W bits)
//            out_valid  - codeword valid
//            out_ready  - sink accepts the codeword
//            out_code   - codeword (CODE_W bits)
//            chk_err    - sticky self-check error (IFNS_SELFCHK_EN only)
// Options  : IFNS_SELFCHK_EN - adds a checker that carries v alongside each
//            word and compares the codeword weight against it at output.
// Revision : 1.0 - initial release
// ============================================================================
module ifns_encoder_pipe #(
  parameter int DATA_W      = 20,
  parameter int CODE_W      = 29,
  parameter int STG_PER_REG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code
`ifdef IFNS_SELFCHK_EN
  ,
  output logic              chk_err
`endif
);

  localparam int NREG = (CODE_W + STG_PER_REG - 1) / STG_PER_REG;
  localparam int RW   = DATA_W + 1;

  // Fibonacci table, index n holds F(n); entries up to F(CODE_W+2) are needed
  // for the capacity check and for the F(i+1) compare of the top stages.
  typedef logic [CODE_W+2:0][63:0] fib_tab_t;

  function automatic fib_tab_t fib_table();
    fib_tab_t t;
    t    = '0;
    t[1] = 64'd1;
    t[2] = 64'd1;
    for (int n = 3; n <= CODE_W + 2; n++) begin
      t[n] = t[n-1] + t[n-2];
    end
    return t;
  endfunction

  localparam fib_tab_t    FIB      = fib_table();
  localparam logic [63:0] MAX_CODE = FIB[CODE_W+2] - 64'd1;
  localparam logic [63:0] MAX_DATA = (64'd1 << DATA_W) - 64'd1;

  generate
    if ((MAX_CODE < MAX_DATA) || (CODE_W < 2) ||
        (STG_PER_REG < 1) || (STG_PER_REG > CODE_W)) begin : g_bad_params
      $error("ifns_encoder_pipe: CODE_W too small for DATA_W or STG_PER_REG out of range");
    end
  endgenerate

  // Per-slot state: remainder, last resolved digit, partial codeword.
  logic [NREG-1:0]             vld_q;
  logic [NREG-1:0]             vld_in;
  logic [NREG-1:0]             adv;
  logic [NREG-1:0][RW-1:0]     r_q,    r_d;
  logic [NREG-1:0]             dg_q,   dg_d;
  logic [NREG-1:0][CODE_W-1:0] code_q, code_d;

  // Slot k may load unless it and every slot downstream are full while the
  // sink stalls; written flat so there is no combinational chain.
  generate
    for (genvar k = 0; k < NREG; k++) begin : g_adv
      assign adv[k] = out_ready | ~(&vld_q[NREG-1:k]);
    end
  endgenerate

  assign vld_in    = NREG'({vld_q, in_valid});
  assign in_ready  = adv[0];
  assign out_valid = vld_q[NREG-1];
  assign out_code  = code_q[NREG-1];

  // Digit stages. Stage s resolves digit i = CODE_W - s; slot k holds the
  // result of stages up to (k+1)*STG_PER_REG-1.
  always_comb begin
    logic [RW-1:0]     r;
    logic              dig;
    logic [CODE_W-1:0] code;
    logic [63:0]       fi;
    logic [63:0]       fi1;
    int                kp;
    int                i;
    r_d    = '0;
    dg_d   = '0;
    code_d = '0;
    r      = '0;
    dig    = 1'b0;
    code   = '0;
    fi     = '0;
    fi1    = '0;
    kp     = 0;
    i      = 0;
    for (int k = 0; k < NREG; k++) begin
      kp = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        r    = RW'(in_data);
        dig  = 1'b0;
        code = '0;
      end else begin
        r    = r_q[kp];
        dig  = dg_q[kp];
        code = code_q[kp];
      end
      for (int s = k * STG_PER_REG; s < (k + 1) * STG_PER_REG; s++) begin
        if (s < CODE_W) begin
          i   = CODE_W - s;
          fi  = FIB[i];
          fi1 = FIB[i+1];
          if (i == CODE_W) begin
            dig = (64'(r) >= fi);
          end else if (i == 1) begin
            dig = r[0];
          end else if (64'(r) >= fi1) begin
            dig = 1'b1;
          end else if (64'(r) < fi) begin
            dig = 1'b0;
          end
          // In the F(i) <= r < F(i+1) window the digit repeats d_(i+1),
          // which is the value already held in dig.
          if (dig) begin
            r = r - fi[RW-1:0];
          end
          code[i-1] = dig;
        end
      end
      r_d[k]    = r;
      dg_d[k]   = dig;
      code_d[k] = code;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= '0;
      r_q    <= '0;
      dg_q   <= '0;
      code_q <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (adv[k]) begin
          vld_q[k]  <= vld_in[k];
          r_q[k]    <= r_d[k];
          dg_q[k]   <= dg_d[k];
          code_q[k] <= code_d[k];
        end
      end
    end
  end

  // The final digit and (without the checker) the final remainder of the
  // last slot have no consumer.
  logic unused_tail;
  assign unused_tail = ^{r_q[NREG-1], dg_q[NREG-1]};

`ifdef IFNS_SELFCHK_EN
  logic [NREG-1:0][DATA_W-1:0] v_q, v_d;
  logic [63:0]                 wsum;
  logic                        chk_err_q;

  always_comb begin
    v_d = '0;
    for (int k = 0; k < NREG; k++) begin
      v_d[k] = (k == 0) ? in_data : v_q[(k == 0) ? 0 : k - 1];
    end
  end

  // Weight of the codeword currently presented at the output.
  always_comb begin
    wsum = '0;
    for (int i = 1; i <= CODE_W; i++) begin
      if (code_q[NREG-1][i-1]) begin
        wsum = wsum + FIB[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q       <= '0;
      chk_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (adv[k]) begin
          v_q[k] <= v_d[k];
        end
      end
      if (vld_q[NREG-1] && out_ready &&
          ((wsum != 64'(v_q[NREG-1])) || (r_q[NREG-1] != '0))) begin
        chk_err_q <= 1'b1;
      end
    end
  end

  assign chk_err = chk_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifns_encoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifns_encoder_pipe
// Purpose  : Self-checking bench for ifns_encoder_pipe. One default-size
//            instance (20/29/4) plus two 8/12 instances (STG_PER_REG 1 and
//            12) for an exhaustive sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifns_encoder_pipe;

  localparam int NREG = 8;   // ceil(29/4)

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [28:0] out_code;

  logic        s_in_valid;
  logic [7:0]  s_in_data;
  logic        s_out_ready;
  logic        a_in_ready, a_out_valid;
  logic [11:0] a_out_code;
  logic        b_in_ready, b_out_valid;
  logic [11:0] b_out_code;
`ifdef IFNS_SELFCHK_EN
  logic        chk_err, a_chk_err, b_chk_err;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ifns_encoder_pipe #(.DATA_W(20), .CODE_W(29), .STG_PER_REG(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code)
`ifdef IFNS_SELFCHK_EN
    , .chk_err(chk_err)
`endif
  );

  ifns_encoder_pipe #(.DATA_W(8), .CODE_W(12), .STG_PER_REG(1)) u_sweep_a (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(a_in_ready),
    .in_data(s_in_data), .out_valid(a_out_valid), .out_ready(s_out_ready),
    .out_code(a_out_code)
`ifdef IFNS_SELFCHK_EN
    , .chk_err(a_chk_err)
`endif
  );

  ifns_encoder_pipe #(.DATA_W(8), .CODE_W(12), .STG_PER_REG(12)) u_sweep_b (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(b_in_ready),
    .in_data(s_in_data), .out_valid(b_out_valid), .out_ready(s_out_ready),
    .out_code(b_out_code)
`ifdef IFNS_SELFCHK_EN
    , .chk_err(b_chk_err)
`endif
  );

  function automatic logic [63:0] fib(input int n);
    logic [63:0] a, b, t;
    a = 64'd1;
    b = 64'd1;
    for (int k = 3; k <= n; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return (n <= 1) ? a : b;
  endfunction

  // Software FNS encoder following the top-down digit rule.
  function automatic logic [63:0] fns_model(input logic [63:0] v, input int cw);
    logic [63:0] r, code;
    logic        d;
    r = v;
    code = '0;
    d = 1'b0;
    for (int i = cw; i >= 1; i--) begin
      if (i == cw)               d = (r >= fib(cw));
      else if (i == 1)           d = r[0];
      else if (r >= fib(i + 1))  d = 1'b1;
      else if (r < fib(i))       d = 1'b0;
      if (d) r = r - fib(i);
      code[i-1] = d;
    end
    return code;
  endfunction

  function automatic logic [63:0] wsum(input logic [63:0] code, input int cw);
    logic [63:0] s;
    s = '0;
    for (int i = 1; i <= cw; i++) if (code[i-1]) s = s + fib(i);
    return s;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    s_in_valid = 1'b0;
    s_in_data = '0;
    s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++;
    if (out_code !== 29'h0) begin n_fail++; $display("FAIL reset_out_code: got %h want 0", out_code); end
`ifdef IFNS_SELFCHK_EN
    n_cmp++;
    if (chk_err !== 1'b0) begin n_fail++; $display("FAIL reset_chk_err: got %b want 0", chk_err); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  // Single word: checks out_valid is low one cycle early, then code and weight.
  task automatic test_encode(input logic [19:0] v, input logic [28:0] exp, input string nm);
    @(negedge clk);
    in_data = v;
    in_valid = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_in_ready: got %b want 1", nm, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (NREG - 2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early: out_valid got %b want 0", nm, out_valid); end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_latency: out_valid got %b want 1", nm, out_valid); end
    n_cmp++;
    if (out_code !== exp) begin n_fail++; $display("FAIL %s_code: got %h want %h", nm, out_code, exp); end
    n_cmp++;
    if (wsum(64'(out_code), 29) !== 64'(v)) begin
      n_fail++; $display("FAIL %s_weight: got %0d want %0d", nm, wsum(64'(out_code), 29), v);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [19:0] q[$];
    logic [19:0] v;
    logic [63:0] e;
    int          acc, got;
    acc = 0;
    got = 0;
    out_ready = 1'b1;
    fork
      begin
        for (int c = 0; c < 300 && acc < 100; c++) begin
          @(negedge clk);
          in_valid = 1'b1;
          in_data = 20'($urandom_range(0, 1048575));
          n_cmp++;
          if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_in_ready: got %b want 1 (word %0d)", in_ready, acc);
          end else begin
            q.push_back(in_data);
            acc++;
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 400 && got < 100; c++) begin
          @(negedge clk);
          if (out_valid === 1'b1) begin
            n_cmp++;
            if (q.size() == 0) begin
              n_fail++; $display("FAIL b2b_spurious: out_valid with no word pending");
            end else begin
              v = q.pop_front();
              e = fns_model(64'(v), 29);
              if (out_code !== e[28:0] || wsum(64'(out_code), 29) !== 64'(v)) begin
                n_fail++; $display("FAIL b2b_code: v=%0d got %h want %h", v, out_code, e[28:0]);
              end
            end
            got++;
          end
        end
      end
    join
    n_cmp++;
    if (got != 100) begin n_fail++; $display("FAIL b2b_count: got %0d want 100", got); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [19:0] q[$];
    logic [19:0] v;
    logic [63:0] e;
    logic [28:0] held;
    bit          have;
    int          acc, got;
    acc = 0;
    got = 0;
    have = 1'b0;
    held = '0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1;
      in_data = 20'(1000 + acc * 37);
      if (in_ready === 1'b1) begin
        q.push_back(in_data);
        acc++;
      end
      if (out_valid === 1'b1) begin
        if (!have) begin
          held = out_code;
          have = 1'b1;
        end else begin
          n_cmp++;
          if (out_code !== held) begin n_fail++; $display("FAIL bp_stable: got %h want %h", out_code, held); end
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++;
    if (acc != NREG) begin n_fail++; $display("FAIL bp_accepted: got %0d want %0d", acc, NREG); end
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got < NREG; c++) begin
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL bp_spurious: out_valid with no word pending");
        end else begin
          v = q.pop_front();
          e = fns_model(64'(v), 29);
          if (out_code !== e[28:0]) begin
            n_fail++; $display("FAIL bp_drain: v=%0d got %h want %h", v, out_code, e[28:0]);
          end
        end
        got++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (got != NREG) begin n_fail++; $display("FAIL bp_drain_count: got %0d want %0d", got, NREG); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    int seen;
    seen = 0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data = 20'(500 + c);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
    in_valid = 1'b1;
    in_data = 20'd7;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (out_valid === 1'b1) begin
        seen++;
        n_cmp++;
        if (c != NREG || out_code !== 29'h000000F) begin
          n_fail++; $display("FAIL mid_rst_output: cycle %0d code %h want cycle %0d code 000000f", c, out_code, NREG);
        end
      end
    end
    n_cmp++;
    if (seen != 1) begin n_fail++; $display("FAIL mid_rst_count: got %0d outputs want 1", seen); end
  endtask

  task automatic test_sweep();
    int ea, eb;
    logic [63:0] e;
    ea = 0;
    eb = 0;
    fork
      begin
        for (int v = 0; v < 256; v++) begin
          @(negedge clk);
          s_in_valid = 1'b1;
          s_in_data = 8'(v);
        end
        @(negedge clk);
        s_in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 400 && ea < 256; c++) begin
          @(negedge clk);
          if (a_out_valid === 1'b1) begin
            e = fns_model(64'(ea), 12);
            n_cmp++;
            if (a_out_code !== e[11:0] || wsum(64'(a_out_code), 12) !== 64'(ea)) begin
              n_fail++; $display("FAIL sweep_stg1: v=%0d got %h want %h", ea, a_out_code, e[11:0]);
            end
            ea++;
          end
        end
      end
      begin
        for (int c = 0; c < 400 && eb < 256; c++) begin
          @(negedge clk);
          if (b_out_valid === 1'b1) begin
            e = fns_model(64'(eb), 12);
            n_cmp++;
            if (b_out_code !== e[11:0] || wsum(64'(b_out_code), 12) !== 64'(eb)) begin
              n_fail++; $display("FAIL sweep_stg12: v=%0d got %h want %h", eb, b_out_code, e[11:0]);
            end
            eb++;
          end
        end
      end
    join
    n_cmp++;
    if (ea != 256 || eb != 256) begin n_fail++; $display("FAIL sweep_count: got %0d/%0d want 256/256", ea, eb); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_encode(20'd0,       29'h0000000, "v0");
    test_encode(20'd1,       29'h0000001, "v1");
    test_encode(20'd2,       29'h0000003, "v2");
    test_encode(20'd3,       29'h0000006, "v3");
    test_encode(20'd7,       29'h000000F, "v7");
    test_encode(20'd832040,  29'h18000000, "v832040");
    test_encode(20'hFFFFF,   29'h1C18F980, "vmax");
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_sweep();
`ifdef IFNS_SELFCHK_EN
    n_cmp++;
    if ({chk_err, a_chk_err, b_chk_err} !== 3'b000) begin
      n_fail++; $display("FAIL selfcheck: chk_err got %b%b%b want 000", chk_err, a_chk_err, b_chk_err);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
